regfile_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between two sources: the pipeline WB stage and a

---
 rtl/regfile_arb_pkg.sv | 22 ++
 rtl/regfile_scoreboard.sv | 35 +++
 rtl/regfile_wb_arbiter.sv | 139 +++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types for the register-file write-port arbiter: FSM states, register-file constants
// and the write-request record used for the LU holding buffer and the grant path.
package regfile_arb_pkg;

  localparam int NUM_REGS = 32;
  localparam int DATA_W = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    FORCE
  } state_t;

  // "reg" is a keyword, so the destination field is regAddr.
  typedef struct packed {
    logic valid;
    logic [4:0] regAddr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: one bit per register with an outstanding long-latency write.
// Set (issue) wins over clear (LU grant) on the same register; register 0 is never marked.
module regfile_scoreboard
  import regfile_arb_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                setEn,
  input  logic [4:0]          setReg,
  input  logic                clrEn,
  input  logic [4:0]          clrReg,
  input  logic [4:0]          rsReg,
  input  logic [4:0]          rtReg,
  output logic [NUM_REGS-1:0] busy,
  output logic                hazardStall
);

  logic [NUM_REGS-1:0] busyNext;

  always_comb begin
    busyNext = busy;
    if (clrEn) busyNext[clrReg] = 1'b0;
    if (setEn && setReg != REG_ZERO) busyNext[setReg] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busyNext;
  end

  // Read ports look at the registered vector only, so a same-cycle issue is not seen yet.
  assign hazardStall = (rsReg != REG_ZERO && busy[rsReg]) ||
                       (rtReg != REG_ZERO && busy[rtReg]);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between the WB stage and a 1-entry LU buffer,
// with WB priority bounded by MAX_WAIT. Optional conflict counter under ARB_CONFLICT_CNT_EN.
//
// LU handshake: a result transfers on a rising edge where lu_valid && lu_ready; lu_ready is high
// when the buffer is empty or is being drained this cycle; lu_reg/lu_data hold while stalled.
module regfile_wb_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int N = 32,
  parameter int MAX_WAIT = 4
`ifdef ARB_CONFLICT_CNT_EN
  , parameter int CNT_W = 16
`endif
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                wb_valid,
  input  logic [4:0]          wb_reg,
  input  logic [N-1:0]        wb_data,
  input  logic                lu_valid,
  output logic                lu_ready,
  input  logic [4:0]          lu_reg,
  input  logic [N-1:0]        lu_data,
  input  logic                issue_valid,
  input  logic [4:0]          issue_reg,
  input  logic [4:0]          rs_reg,
  input  logic [4:0]          rt_reg,
  output logic                hazard_stall,
  output logic                wb_stall,
  output logic                RegWrite,
  output logic [4:0]          WriteRegister,
  output logic [N-1:0]        WriteData,
  output state_t              dbgState,
  output logic [NUM_REGS-1:0] busy_vector
`ifdef ARB_CONFLICT_CNT_EN
  , output logic [CNT_W-1:0]  conflict_count
`endif
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);
  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t     state, stateNext;
  wr_req_t    luBuf, luBufNext, grant;
  logic [3:0] waitCnt, waitCntNext;
  logic       luGrant;

  always_comb begin
    stateNext   = state;
    luBufNext   = luBuf;
    waitCntNext = waitCnt;
    grant       = '0;
    luGrant     = 1'b0;
    lu_ready    = 1'b0;
    wb_stall    = 1'b0;

    case (state)
      IDLE: begin
        lu_ready = 1'b1;
        if (wb_valid) grant = '{valid: 1'b1, regAddr: wb_reg, data: DATA_W'(wb_data)};
      end
      HELD: begin
        if (wb_valid) begin
          grant = '{valid: 1'b1, regAddr: wb_reg, data: DATA_W'(wb_data)};
          if (waitCnt != WAIT_MAX) waitCntNext = waitCnt + 4'd1;
          if (waitCnt >= WAIT_LAST) stateNext = FORCE;
        end else begin
          luGrant  = 1'b1;
          lu_ready = 1'b1;
        end
      end
      FORCE: begin
        wb_stall = 1'b1;
        luGrant  = 1'b1;
        lu_ready = 1'b1;
      end
      default: stateNext = IDLE;
    endcase

    if (luGrant) begin
      grant           = luBuf;
      luBufNext.valid = 1'b0;
      waitCntNext     = '0;
      stateNext       = IDLE;
    end

    // A refill in the draining cycle keeps the buffer full.
    if (lu_valid && lu_ready) begin
      luBufNext = '{valid: 1'b1, regAddr: lu_reg, data: DATA_W'(lu_data)};
      stateNext = HELD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      luBuf         <= '0;
      waitCnt       <= '0;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      state    <= stateNext;
      luBuf    <= luBufNext;
      waitCnt  <= waitCntNext;
      // A grant to register 0 is consumed but never reaches the register file.
      RegWrite <= grant.valid && grant.regAddr != REG_ZERO;
      if (grant.valid) begin
        WriteRegister <= grant.regAddr;
        WriteData     <= N'(grant.data);
      end
    end
  end

  assign dbgState = state;

  regfile_scoreboard u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .setEn       (issue_valid),
    .setReg      (issue_reg),
    .clrEn       (luGrant),
    .clrReg      (luBuf.regAddr),
    .rsReg       (rs_reg),
    .rtReg       (rt_reg),
    .busy        (busy_vector),
    .hazardStall (hazard_stall)
  );

`ifdef ARB_CONFLICT_CNT_EN
  // Cycles where WB competes with a full buffer, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) conflict_count <= '0;
    else if (wb_valid && state != IDLE && conflict_count != '1)
      conflict_count <= conflict_count + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus random WB traffic,
// with register-file writes checked against an expected queue.
module tb_regfile_wb_arbiter;
  import regfile_arb_pkg::*;

  localparam int N = 32;
  localparam int W = 5 + N;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wb_valid, lu_valid, issue_valid;
  logic [4:0]    wb_reg, lu_reg, issue_reg, rs_reg, rt_reg;
  logic [N-1:0]  wb_data, lu_data;
  logic          lu_ready, hazard_stall, wb_stall, RegWrite;
  logic [4:0]    WriteRegister;
  logic [N-1:0]  WriteData;
  state_t        dbg_state;
  logic [31:0]   busy_vector;
`ifdef ARB_CONFLICT_CNT_EN
  logic [15:0]   conflict_count;
`endif

  int tests_run = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int got_rd = 0;

  regfile_wb_arbiter #(.N(N), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_reg(lu_reg), .lu_data(lu_data),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .rs_reg(rs_reg), .rt_reg(rt_reg),
    .hazard_stall(hazard_stall), .wb_stall(wb_stall),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .dbgState(dbg_state), .busy_vector(busy_vector)
`ifdef ARB_CONFLICT_CNT_EN
    , .conflict_count(conflict_count)
`endif
  );

  // ---------------- clock / monitor ----------------
  always #5 clk = ~clk;

  always @(negedge clk)
    if (reset === 1'b1 && RegWrite === 1'b1) got_q.push_back({WriteRegister, WriteData});

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    wb_valid = 0; wb_reg = 0; wb_data = 0;
    lu_valid = 0; lu_reg = 0; lu_data = 0;
    issue_valid = 0; issue_reg = 0; rs_reg = 0; rt_reg = 0;
  endtask

  task automatic drive_wb(input logic [4:0] r, input logic [N-1:0] d);
    wb_valid = 1; wb_reg = r; wb_data = d;
  endtask

  task automatic drive_lu(input logic [4:0] r, input logic [N-1:0] d);
    lu_valid = 1; lu_reg = r; lu_data = d;
  endtask

  task automatic push_exp(input logic [4:0] r, input logic [N-1:0] d);
    exp_q.push_back({r, d});
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] e, g;
    drive_idle();
    reset = 0;
    #1;
    tests_run++;
    if (RegWrite !== 0 || WriteRegister !== 0 || WriteData !== 0 || busy_vector !== 0) begin
      fails++; $display("FAIL reset_outputs got RegWrite=%b reg=%0d data=%h busy=%h expected all 0",
                        RegWrite, WriteRegister, WriteData, busy_vector);
    end
    repeat (2) @(posedge clk);
    #3 reset = 1;
    cyc();
    drive_wb(5'd4, 32'h44); drive_lu(5'd3, 32'h55);
    issue_valid = 1; issue_reg = 5'd3;
    push_exp(5'd4, 32'h44);
    cyc();
    drive_idle(); drive_wb(5'd6, 32'h66);
    @(negedge clk);
    tests_run++;
    if (lu_ready !== 0 || busy_vector[3] !== 1 || dbg_state !== HELD) begin
      fails++; $display("FAIL reset_prefill got lu_ready=%b busy3=%b state=%0d expected 0,1,HELD",
                        lu_ready, busy_vector[3], dbg_state);
    end
    #1 reset = 0;
    #1;
    tests_run++;
    if (RegWrite !== 0 || WriteRegister !== 0 || WriteData !== 0 || busy_vector !== 0 || wb_stall !== 0) begin
      fails++; $display("FAIL reset_midstream got RegWrite=%b reg=%0d data=%h busy=%h stall=%b expected all 0",
                        RegWrite, WriteRegister, WriteData, busy_vector, wb_stall);
    end
    drive_idle();
    repeat (2) @(posedge clk);
    #3 reset = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      tests_run++;
      if (RegWrite !== 0 || lu_ready !== 1) begin
        fails++; $display("FAIL reset_release cycle %0d got RegWrite=%b lu_ready=%b expected 0,1", i, RegWrite, lu_ready);
      end
    end
    tests_run++;
    if (got_q.size() - got_rd !== exp_q.size()) begin
      fails++; $display("FAIL reset_sb_count got=%0d expected=%0d", got_q.size() - got_rd, exp_q.size());
    end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front(); g = got_q[got_rd]; got_rd++;
      tests_run++;
      if (g !== e) begin fails++; $display("FAIL reset_sb_data got=%h expected=%h", g, e); end
    end
    exp_q.delete(); got_rd = got_q.size();
  endtask

  task automatic test_wb_write();
    logic [W-1:0] e, g;
    drive_idle();
    cyc();
    drive_wb(5'd8, 32'h11);
    push_exp(5'd8, 32'h11);
    cyc();
    drive_idle();
    @(negedge clk);
    tests_run++;
    if (RegWrite !== 1 || WriteRegister !== 8 || WriteData !== 32'h11) begin
      fails++; $display("FAIL wb_write got we=%b reg=%0d data=%h expected 1,8,11", RegWrite, WriteRegister, WriteData);
    end
    cyc();
    @(negedge clk);
    tests_run++;
    if (RegWrite !== 0) begin fails++; $display("FAIL wb_write_idle got we=%b expected 0", RegWrite); end
    tests_run++;
    if (got_q.size() - got_rd !== exp_q.size()) begin
      fails++; $display("FAIL wb_sb_count got=%0d expected=%0d", got_q.size() - got_rd, exp_q.size());
    end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front(); g = got_q[got_rd]; got_rd++;
      tests_run++;
      if (g !== e) begin fails++; $display("FAIL wb_sb_data got=%h expected=%h", g, e); end
    end
    exp_q.delete(); got_rd = got_q.size();
  endtask

  task automatic test_lu_path();
    logic [W-1:0] e, g;
    drive_idle();
    cyc();
    issue_valid = 1; issue_reg = 5'd9;
    cyc();
    drive_idle(); rs_reg = 5'd9;
    @(negedge clk);
    tests_run++;
    if (busy_vector[9] !== 1 || hazard_stall !== 1) begin
      fails++; $display("FAIL lu_busy_rs got busy9=%b hazard=%b expected 1,1", busy_vector[9], hazard_stall);
    end
    rs_reg = 0; rt_reg = 5'd9;
    #1;
    tests_run++;
    if (hazard_stall !== 1) begin fails++; $display("FAIL lu_busy_rt got hazard=%b expected 1", hazard_stall); end
    rt_reg = 0; rs_reg = 5'd10;
    #1;
    tests_run++;
    if (hazard_stall !== 0) begin fails++; $display("FAIL lu_free_rs got hazard=%b expected 0", hazard_stall); end
    cyc();
    drive_idle(); rs_reg = 5'd9;
    drive_lu(5'd9, 32'hAB);
    cyc();
    lu_valid = 0;
    push_exp(5'd9, 32'hAB);
    @(negedge clk);
    tests_run++;
    if (lu_ready !== 1 || busy_vector[9] !== 1 || dbg_state !== HELD) begin
      fails++; $display("FAIL lu_drain got lu_ready=%b busy9=%b state=%0d expected 1,1,HELD", lu_ready, busy_vector[9], dbg_state);
    end
    cyc();
    @(negedge clk);
    tests_run++;
    if (RegWrite !== 1 || WriteRegister !== 9 || WriteData !== 32'hAB || busy_vector[9] !== 0 || hazard_stall !== 0) begin
      fails++; $display("FAIL lu_write got we=%b reg=%0d data=%h busy9=%b hazard=%b expected 1,9,ab,0,0",
                        RegWrite, WriteRegister, WriteData, busy_vector[9], hazard_stall);
    end
    drive_idle();
    cyc();
    tests_run++;
    if (got_q.size() - got_rd !== exp_q.size()) begin
      fails++; $display("FAIL lu_sb_count got=%0d expected=%0d", got_q.size() - got_rd, exp_q.size());
    end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front(); g = got_q[got_rd]; got_rd++;
      tests_run++;
      if (g !== e) begin fails++; $display("FAIL lu_sb_data got=%h expected=%h", g, e); end
    end
    exp_q.delete(); got_rd = got_q.size();
  endtask

  task automatic test_force();
    logic [W-1:0] e, g;
`ifdef ARB_CONFLICT_CNT_EN
    logic [15:0] cc0;
`endif
    drive_idle();
    cyc();
`ifdef ARB_CONFLICT_CNT_EN
    cc0 = conflict_count;
`endif
    drive_lu(5'd12, 32'hC0DE);
    cyc();
    lu_valid = 0;
    for (int k = 0; k < 4; k++) begin
      drive_wb(5'(20 + k), 32'h100 + k);
      push_exp(5'(20 + k), 32'h100 + k);
      @(negedge clk);
      tests_run++;
      if (wb_stall !== 0 || lu_ready !== 0) begin
        fails++; $display("FAIL force_wait cycle %0d got stall=%b lu_ready=%b expected 0,0", k, wb_stall, lu_ready);
      end
      cyc();
    end
    drive_wb(5'd25, 32'h99);
    push_exp(5'd12, 32'hC0DE);
    @(negedge clk);
    tests_run++;
    if (wb_stall !== 1 || lu_ready !== 1 || dbg_state !== FORCE) begin
      fails++; $display("FAIL force_state got stall=%b lu_ready=%b state=%0d expected 1,1,FORCE", wb_stall, lu_ready, dbg_state);
    end
    cyc();
    push_exp(5'd25, 32'h99);
    @(negedge clk);
    tests_run++;
    if (wb_stall !== 0 || RegWrite !== 1 || WriteRegister !== 12 || WriteData !== 32'hC0DE) begin
      fails++; $display("FAIL force_grant got stall=%b we=%b reg=%0d data=%h expected 0,1,12,c0de",
                        wb_stall, RegWrite, WriteRegister, WriteData);
    end
    cyc();
    drive_idle();
    @(negedge clk);
    tests_run++;
    if (RegWrite !== 1 || WriteRegister !== 25) begin
      fails++; $display("FAIL force_wb_retry got we=%b reg=%0d expected 1,25", RegWrite, WriteRegister);
    end
`ifdef ARB_CONFLICT_CNT_EN
    tests_run++;
    if (conflict_count - cc0 !== 16'd5) begin
      fails++; $display("FAIL conflict_count got delta=%0d expected 5", conflict_count - cc0);
    end
`endif
    cyc();
    tests_run++;
    if (got_q.size() - got_rd !== exp_q.size()) begin
      fails++; $display("FAIL force_sb_count got=%0d expected=%0d", got_q.size() - got_rd, exp_q.size());
    end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front(); g = got_q[got_rd]; got_rd++;
      tests_run++;
      if (g !== e) begin fails++; $display("FAIL force_sb_data got=%h expected=%h", g, e); end
    end
    exp_q.delete(); got_rd = got_q.size();
  endtask

  task automatic test_wait_clear();
    logic [W-1:0] e, g;
    drive_idle();
    cyc();
    drive_lu(5'd14, 32'hA1);
    cyc();
    lu_valid = 0;
    for (int k = 0; k < 3; k++) begin
      drive_wb(5'(15 + k), 32'h150 + k);
      push_exp(5'(15 + k), 32'h150 + k);
      cyc();
    end
    wb_valid = 0;
    drive_lu(5'd18, 32'hB2);
    push_exp(5'd14, 32'hA1);
    @(negedge clk);
    tests_run++;
    if (lu_ready !== 1) begin fails++; $display("FAIL wait_refill got lu_ready=%b expected 1", lu_ready); end
    cyc();
    lu_valid = 0;
    for (int k = 0; k < 3; k++) begin
      drive_wb(5'(19 + k), 32'h190 + k);
      push_exp(5'(19 + k), 32'h190 + k);
      @(negedge clk);
      tests_run++;
      if (wb_stall !== 0 || lu_ready !== 0) begin
        fails++; $display("FAIL wait_cleared cycle %0d got stall=%b lu_ready=%b expected 0,0", k, wb_stall, lu_ready);
      end
      cyc();
    end
    drive_idle();
    push_exp(5'd18, 32'hB2);
    cyc();
    cyc();
    tests_run++;
    if (got_q.size() - got_rd !== exp_q.size()) begin
      fails++; $display("FAIL wait_sb_count got=%0d expected=%0d", got_q.size() - got_rd, exp_q.size());
    end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front(); g = got_q[got_rd]; got_rd++;
      tests_run++;
      if (g !== e) begin fails++; $display("FAIL wait_sb_data got=%h expected=%h", g, e); end
    end
    exp_q.delete(); got_rd = got_q.size();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e, g;
    drive_idle();
    cyc();
    for (int k = 1; k <= 4; k++) begin
      if (k <= 3) begin
        drive_lu(5'(k), 32'hB00 + k);
        push_exp(5'(k), 32'hB00 + k);
      end else begin
        lu_valid = 0;
      end
      @(negedge clk);
      tests_run++;
      if (lu_ready !== 1) begin fails++; $display("FAIL b2b_ready cycle %0d got lu_ready=%b expected 1", k, lu_ready); end
      cyc();
    end
    drive_idle();
    @(negedge clk);
    tests_run++;
    if (RegWrite !== 1 || WriteRegister !== 3) begin
      fails++; $display("FAIL b2b_last got we=%b reg=%0d expected 1,3", RegWrite, WriteRegister);
    end
    cyc();
    tests_run++;
    if (got_q.size() - got_rd !== exp_q.size()) begin
      fails++; $display("FAIL b2b_sb_count got=%0d expected=%0d", got_q.size() - got_rd, exp_q.size());
    end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front(); g = got_q[got_rd]; got_rd++;
      tests_run++;
      if (g !== e) begin fails++; $display("FAIL b2b_sb_data got=%h expected=%h", g, e); end
    end
    exp_q.delete(); got_rd = got_q.size();
  endtask

  task automatic test_reg_zero();
    logic [W-1:0] e, g;
    drive_idle();
    cyc();
    issue_valid = 1; issue_reg = 5'd0;
    drive_wb(5'd0, 32'h77);
    drive_lu(5'd0, 32'hEE);
    cyc();
    drive_idle();
    @(negedge clk);
    tests_run++;
    if (RegWrite !== 0 || busy_vector !== 0 || dbg_state !== HELD) begin
      fails++; $display("FAIL zero_wb got we=%b busy=%h state=%0d expected 0,0,HELD", RegWrite, busy_vector, dbg_state);
    end
    cyc();
    drive_wb(5'd7, 32'h70);
    push_exp(5'd7, 32'h70);
    @(negedge clk);
    tests_run++;
    if (RegWrite !== 0 || lu_ready !== 1 || busy_vector !== 0) begin
      fails++; $display("FAIL zero_lu got we=%b lu_ready=%b busy=%h expected 0,1,0", RegWrite, lu_ready, busy_vector);
    end
    cyc();
    drive_idle();
    @(negedge clk);
    tests_run++;
    if (RegWrite !== 1 || WriteRegister !== 7 || WriteData !== 32'h70) begin
      fails++; $display("FAIL zero_after got we=%b reg=%0d data=%h expected 1,7,70", RegWrite, WriteRegister, WriteData);
    end
    cyc();
    tests_run++;
    if (got_q.size() - got_rd !== exp_q.size()) begin
      fails++; $display("FAIL zero_sb_count got=%0d expected=%0d", got_q.size() - got_rd, exp_q.size());
    end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front(); g = got_q[got_rd]; got_rd++;
      tests_run++;
      if (g !== e) begin fails++; $display("FAIL zero_sb_data got=%h expected=%h", g, e); end
    end
    exp_q.delete(); got_rd = got_q.size();
  endtask

  task automatic test_same_cycle();
    logic [W-1:0] e, g;
    drive_idle();
    cyc();
    issue_valid = 1; issue_reg = 5'd5;
    cyc();
    drive_idle();
    drive_lu(5'd5, 32'h55AA);
    cyc();
    drive_idle();
    issue_valid = 1; issue_reg = 5'd5;
    push_exp(5'd5, 32'h55AA);
    cyc();
    drive_idle(); rt_reg = 5'd5;
    @(negedge clk);
    tests_run++;
    if (busy_vector[5] !== 1 || hazard_stall !== 1 || RegWrite !== 1 || WriteRegister !== 5) begin
      fails++; $display("FAIL same_cycle_set got busy5=%b hazard=%b we=%b reg=%0d expected 1,1,1,5",
                        busy_vector[5], hazard_stall, RegWrite, WriteRegister);
    end
    cyc();
    drive_lu(5'd5, 32'h5A5A);
    cyc();
    drive_idle();
    push_exp(5'd5, 32'h5A5A);
    cyc();
    @(negedge clk);
    tests_run++;
    if (busy_vector[5] !== 0) begin fails++; $display("FAIL same_cycle_clear got busy5=%b expected 0", busy_vector[5]); end
    cyc();
    tests_run++;
    if (got_q.size() - got_rd !== exp_q.size()) begin
      fails++; $display("FAIL same_sb_count got=%0d expected=%0d", got_q.size() - got_rd, exp_q.size());
    end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front(); g = got_q[got_rd]; got_rd++;
      tests_run++;
      if (g !== e) begin fails++; $display("FAIL same_sb_data got=%h expected=%h", g, e); end
    end
    exp_q.delete(); got_rd = got_q.size();
  endtask

  task automatic test_random_wb();
    logic [W-1:0] e, g;
    logic [4:0] r;
    logic [N-1:0] d;
    drive_idle();
    cyc();
    for (int k = 0; k < 20; k++) begin
      r = 5'($urandom_range(1, 31));
      d = $urandom;
      drive_wb(r, d);
      push_exp(r, d);
      cyc();
    end
    drive_idle();
    cyc();
    cyc();
    tests_run++;
    if (got_q.size() - got_rd !== exp_q.size()) begin
      fails++; $display("FAIL rand_sb_count got=%0d expected=%0d", got_q.size() - got_rd, exp_q.size());
    end
    while (exp_q.size() > 0 && got_rd < got_q.size()) begin
      e = exp_q.pop_front(); g = got_q[got_rd]; got_rd++;
      tests_run++;
      if (g !== e) begin fails++; $display("FAIL rand_sb_data got=%h expected=%h", g, e); end
    end
    exp_q.delete(); got_rd = got_q.size();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_wb_write();
    test_lu_path();
    test_force();
    test_wait_clear();
    test_back_to_back();
    test_reg_zero();
    test_same_cycle();
    test_random_wb();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
